// File: rtl/player_move_ctrl_pkg.sv
// Shared tile codes, direction encodings, grid defaults and FSM encodings for the player movement block.
// Pure declarations: no latency and no flow control.
package game_pkg;

  localparam int MAP_W_DEF = 20;
  localparam int MAP_H_DEF = 10;

  localparam logic [2:0] MAP_ROAD0  = 3'b000;
  localparam logic [2:0] MAP_ROAD1  = 3'b001;
  localparam logic [2:0] MAP_WALL   = 3'b010;
  localparam logic [2:0] MAP_STAIRS = 3'b011;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_QUERY = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } coord_t;

  // Codes 1xx are undefined and behave as wall.
  function automatic logic tile_walkable(input logic [2:0] tile);
    return (tile == MAP_ROAD0) || (tile == MAP_ROAD1) || (tile == MAP_STAIRS);
  endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Direction request handshake plus the map store's x/y read port, grouped for the mover.
// master = requester/map side, slave = player_move_ctrl; map_tile answers map_x/map_y combinationally.
interface player_move_ctrl_if;

  logic       dir_valid;
  logic [1:0] dir;
  logic       dir_ready;
  logic [5:0] map_x;
  logic [5:0] map_y;
  logic [2:0] map_tile;

  modport master (
    output dir_valid,
    output dir,
    output map_tile,
    input  dir_ready,
    input  map_x,
    input  map_y
  );

  modport slave (
    input  dir_valid,
    input  dir,
    input  map_tile,
    output dir_ready,
    output map_x,
    output map_y
  );

endinterface

// File: rtl/player_move_ctrl_cooldown.sv
// Loadable down-counter for the post-move idle window; done is high once one cycle remains (or none).
// No flow control; clr (respawn) has priority over load.
module move_cooldown_timer #(
  parameter int COOLDOWN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic done
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(COOLDOWN);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With COOLDOWN=0 the count never leaves zero, so done is permanently high.
  assign done = (cnt_q <= CW'(1));

endmodule

// File: rtl/player_move_ctrl.sv
// Grid mover: accepts a one-step request, queries the target tile, commits/rejects (result at N+2, edge bump at N+1).
// dir_ready only in IDLE without respawn; requests while busy are dropped, not queued.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int MAP_W    = MAP_W_DEF,
  parameter int MAP_H    = MAP_H_DEF,
  parameter int START_X  = 1,
  parameter int START_Y  = 1,
  parameter int COOLDOWN = 4,
  parameter int STEP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  player_move_ctrl_if.slave mv,
  input  logic              respawn,
  output logic [5:0]        pos_x,
  output logic [5:0]        pos_y,
  output logic [STEP_W-1:0] step_count,
  output logic              bump,
  output logic              on_stairs,
  output logic              busy
);

  localparam coord_t     START    = coord_t'({6'(START_X), 6'(START_Y)});
  localparam logic [5:0] X_MAX    = 6'(MAP_W - 1);
  localparam logic [5:0] Y_MAX    = 6'(MAP_H - 1);
  localparam logic [1:0] ST_AFTER = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;

  logic [1:0]        state_q, state_d;
  coord_t            pos_q, pos_d;
  coord_t            map_q, map_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              bump_q, bump_d;
  logic              stairs_q, stairs_d;

  coord_t tgt;
  logic   oob;
  logic   dir_ready;
  logic   accept;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_done;

  assign dir_ready = (state_q == ST_IDLE) && !respawn;
  assign accept    = mv.dir_valid && dir_ready;

  always_comb begin
    tgt = pos_q;
    oob = 1'b0;
    case (mv.dir)
      DIR_UP: begin
        oob   = (pos_q.y == 6'd0);
        tgt.y = pos_q.y - 6'd1;
      end
      DIR_DOWN: begin
        oob   = (pos_q.y >= Y_MAX);
        tgt.y = pos_q.y + 6'd1;
      end
      DIR_LEFT: begin
        oob   = (pos_q.x == 6'd0);
        tgt.x = pos_q.x - 6'd1;
      end
      default: begin
        oob   = (pos_q.x >= X_MAX);
        tgt.x = pos_q.x + 6'd1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    map_d    = map_q;
    step_d   = step_q;
    bump_d   = 1'b0;
    stairs_d = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    // Respawn discards any in-flight query; the step counter is kept across levels.
    if (respawn) begin
      state_d = ST_IDLE;
      pos_d   = START;
      map_d   = START;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (oob) begin
              bump_d   = 1'b1;
              state_d  = ST_AFTER;
              tmr_load = 1'b1;
            end else begin
              map_d   = tgt;
              state_d = ST_QUERY;
            end
          end
        end
        ST_QUERY: begin
          // map_q still holds the target while the tile is sampled.
          if (tile_walkable(mv.map_tile)) begin
            pos_d    = map_q;
            stairs_d = (mv.map_tile == MAP_STAIRS);
            if (step_q != '1) begin
              step_d = step_q + STEP_W'(1);
            end
          end else begin
            map_d  = pos_q;
            bump_d = 1'b1;
          end
          state_d  = ST_AFTER;
          tmr_load = 1'b1;
        end
        ST_COOL: begin
          tmr_dec = 1'b1;
          if (tmr_done) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= START;
      map_q    <= START;
      step_q   <= '0;
      bump_q   <= 1'b0;
      stairs_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      map_q    <= map_d;
      step_q   <= step_d;
      bump_q   <= bump_d;
      stairs_q <= stairs_d;
    end
  end

  move_cooldown_timer #(
    .COOLDOWN (COOLDOWN)
  ) u_cooldown (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .clr  (respawn),
    .done (tmr_done)
  );

  assign mv.dir_ready = dir_ready;
  assign mv.map_x     = map_q.x;
  assign mv.map_y     = map_q.y;
  assign pos_x        = pos_q.x;
  assign pos_y        = pos_q.y;
  assign step_count   = step_q;
  assign bump         = bump_q;
  assign on_stairs    = stairs_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus random requests against a transaction-timeline model.
// The model predicts positions and the edge numbers at which results, pulses and readiness appear.
module tb_player_move_ctrl;
  import game_pkg::*;

  localparam int W  = 20;
  localparam int H  = 10;
  localparam int SX = 1;
  localparam int SY = 1;
  localparam int CD = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          respawn;
  logic [5:0]    pos_x, pos_y;
  logic [SW-1:0] step_count;
  logic          bump, on_stairs, busy;

  player_move_ctrl_if mif ();

  player_move_ctrl #(
    .MAP_W(W), .MAP_H(H), .START_X(SX), .START_Y(SY), .COOLDOWN(CD), .STEP_W(SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mv         (mif.slave),
    .respawn    (respawn),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .step_count (step_count),
    .bump       (bump),
    .on_stairs  (on_stairs),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [2:0] tmap [W][H];

  always_comb begin
    if (int'(mif.map_x) < W && int'(mif.map_y) < H) mif.map_tile = tmap[int'(mif.map_x)][int'(mif.map_y)];
    else mif.map_tile = 3'b010;
  end

  int n_chk = 0, n_pass = 0;
  int t, ready_edge, q_edge, q_tx, q_ty;
  int m_px, m_py, m_mx, m_my, m_step;
  bit m_bump, m_stairs, q_pend, obs_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, exp);
  endtask

  task automatic model_reset();
    m_px = SX; m_py = SY; m_mx = SX; m_my = SY; m_step = 0;
    m_bump = 0; m_stairs = 0; q_pend = 0; ready_edge = t;
  endtask

  task automatic check_outputs();
    chk("pos_x", pos_x, m_px);
    chk("pos_y", pos_y, m_py);
    chk("map_x", mif.map_x, m_mx);
    chk("map_y", mif.map_y, m_my);
    chk("step_count", step_count, m_step);
    chk("bump", bump, m_bump);
    chk("on_stairs", on_stairs, m_stairs);
    chk("busy", busy, t < ready_edge);
  endtask

  // Present inputs for the coming edge, predict its effect, then check after it.
  task automatic step(input logic v, input logic [1:0] d, input logic rs);
    int tx, ty;
    logic [2:0] tile;
    mif.dir_valid = v; mif.dir = d; respawn = rs;
    #1;
    obs_ready = mif.dir_ready;
    chk("dir_ready", mif.dir_ready, (t >= ready_edge) && !rs);
    m_bump = 0; m_stairs = 0;
    if (rs) begin
      m_px = SX; m_py = SY; m_mx = SX; m_my = SY;
      q_pend = 0; ready_edge = t + 1;
    end else if (q_pend && q_edge == t + 1) begin
      q_pend = 0;
      tile = tmap[q_tx][q_ty];
      if (tile == 3'd0 || tile == 3'd1 || tile == 3'd3) begin
        m_px = q_tx; m_py = q_ty;
        if (m_step < (1 << SW) - 1) m_step++;
        m_stairs = (tile == 3'd3);
      end else begin
        m_bump = 1; m_mx = m_px; m_my = m_py;
      end
    end else if (v && t >= ready_edge) begin
      tx = m_px; ty = m_py;
      case (d)
        2'd0: ty = ty - 1;
        2'd1: ty = ty + 1;
        2'd2: tx = tx - 1;
        default: tx = tx + 1;
      endcase
      if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin
        m_bump = 1; ready_edge = t + 1 + CD;
      end else begin
        m_mx = tx; m_my = ty; q_pend = 1; q_tx = tx; q_ty = ty;
        q_edge = t + 2; ready_edge = t + 2 + CD;
      end
    end
    @(negedge clk);
    t++;
    check_outputs();
  endtask

  task automatic idle_wait();
    int n = 0;
    while (busy && n < 40) begin
      step(1'b0, 2'd0, 1'b0);
      n++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic move(input logic [1:0] d);
    step(1'b1, d, 1'b0);
    idle_wait();
  endtask

  task automatic do_respawn();
    step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic goto_14_2();
    do_respawn();
    move(DIR_DOWN);
    for (int i = 0; i < 13; i++) move(DIR_RIGHT);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, low, s0, r;
    rst = 1'b1; respawn = 1'b0; mif.dir_valid = 1'b0; mif.dir = 2'd0; t = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) tmap[x][y] = 3'b000;
    tmap[2][1] = 3'b001; tmap[1][0] = 3'b010; tmap[14][1] = 3'b011;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_dir_ready", mif.dir_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Road1 move right, then result lands two edges after acceptance.
    step(1'b1, DIR_RIGHT, 1'b0);
    chk("A_query_map_x", mif.map_x, 6'd2);
    chk("A_pos_held", pos_x, 6'd1);
    step(1'b0, 2'd0, 1'b0);
    chk("A_pos_x", pos_x, 6'd2);
    idle_wait();
    chk("A_steps", step_count, 16'd1);

    // Wall above start: bump, position and read port restored.
    do_respawn();
    move(DIR_UP);
    chk("B_pos", {pos_x, pos_y}, {6'd1, 6'd1});
    chk("B_map", {mif.map_x, mif.map_y}, {6'd1, 6'd1});

    // Stairs arrival.
    goto_14_2();
    s0 = int'(step_count);
    move(DIR_UP);
    chk("C_pos", {pos_x, pos_y}, {6'd14, 6'd1});
    chk("C_steps", step_count, 16'(s0 + 1));

    // Edges: left at x=0, up at y=0, down at y=H-1, right at x=W-1.
    do_respawn();
    move(DIR_LEFT);
    s0 = int'(step_count);
    step(1'b1, DIR_LEFT, 1'b0);
    chk("D_left_bump_n1", bump, 1'b1);
    chk("D_left_map_x", mif.map_x, 6'd0);
    idle_wait();
    chk("D_left_steps", step_count, 16'(s0));
    move(DIR_UP);
    move(DIR_UP);
    for (int i = 0; i < H; i++) move(DIR_DOWN);
    chk("D_bottom", pos_y, 6'(H - 1));
    for (int i = 0; i < W; i++) move(DIR_RIGHT);
    chk("D_right", pos_x, 6'(W - 1));

    // Held request: one acceptance every six cycles.
    do_respawn();
    acc = 0; low = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, DIR_RIGHT, 1'b0);
      if (obs_ready) acc++; else low++;
    end
    chk("E_accepts", acc, 10);
    chk("E_ready_low", low, 50);
    idle_wait();
    chk("E_pos_x", pos_x, 6'd11);

    // Respawn in the QUERY cycle of a stairs move, then respawn with a request.
    goto_14_2();
    s0 = int'(step_count);
    step(1'b1, DIR_UP, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    chk("F_pos", {pos_x, pos_y}, {6'(SX), 6'(SY)});
    chk("F_no_stairs", on_stairs, 1'b0);
    step(1'b1, DIR_RIGHT, 1'b1);
    step(1'b0, 2'd0, 1'b0);
    chk("F_dropped_pos", pos_x, 6'(SX));
    chk("F_steps", step_count, 16'(s0));

    // Asynchronous reset during COOL.
    step(1'b1, DIR_RIGHT, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    chk("G_in_cool", busy, 1'b1);
    mif.dir_valid = 1'b0; respawn = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("G_pos", {pos_x, pos_y}, {6'(SX), 6'(SY)});
    chk("G_map", {mif.map_x, mif.map_y}, {6'(SX), 6'(SY)});
    chk("G_steps", step_count, 16'd0);
    chk("G_busy", busy, 1'b0);
    @(negedge clk);
    t++;
    rst = 1'b0;
    model_reset();
    #1;
    chk("G_ready_after", mif.dir_ready, 1'b1);
    check_outputs();

    // Random map and random traffic.
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        r = $urandom_range(0, 9);
        if (r < 6) tmap[x][y] = 3'(r & 1);
        else if (r == 6) tmap[x][y] = 3'b010;
        else if (r == 7) tmap[x][y] = 3'b011;
        else tmap[x][y] = 3'(4 + $urandom_range(0, 3));
      end
    tmap[SX][SY] = 3'b000;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Grid-movement controller for the player token. It is the reader side of the tile-map store.
- Accepts one-step direction requests, bounds-checks the target, and fetches the target tile code over the map store's combinational x/y read port.
- Then commits or rejects the move, and flags wall bumps and stairs arrival.
- Feeds pos_x/pos_y to the renderer and on_stairs to the level sequencer, which drives sw_map and pulses respawn.

Parameters:
- MAP_W, 20, grid width in tiles; legal x is 0..MAP_W-1.
- MAP_H, 10, grid height in tiles; legal y is 0..MAP_H-1.
- START_X, 1, x position after reset and after respawn.
- START_Y, 1, y position after reset and after respawn.
- COOLDOWN, 4, idle cycles after any resolved request; 0 means no cooldown.
- STEP_W, 16, width of the step counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dir_valid  in  1  direction request valid
- dir  in  2  00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- dir_ready  out  1  high when the block can accept a request
- respawn  in  1  synchronous pulse; return to start (level change)
- map_x  out  6  map read-port column (registered)
- map_y  out  6  map read-port row (registered)
- map_tile  in  3  tile code returned combinationally for map_x/map_y
- pos_x  out  6  current player column
- pos_y  out  6  current player row
- step_count  out  STEP_W  committed moves since rst
- bump  out  1  one-cycle pulse: move rejected (wall, undefined code, or edge)
- on_stairs  out  1  one-cycle pulse: move committed onto a stairs tile
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - state IDLE.
  - pos_x = map_x = START_X; pos_y = map_y = START_Y.
  - step_count = 0; bump = on_stairs = 0.
  - dir_ready = 1; busy = 0.
- Tile codes: 000 road0, 001 road1, 010 wall, 011 stairs. Codes 1xx are treated as wall.
- dir_ready is combinational: (state==IDLE) && !respawn.
- FSM states: IDLE, QUERY, COOL.
- IDLE:
  - On dir_valid && dir_ready at cycle N, compute the target (tx, ty).
  - Out of bounds means x-1 at x=0, x+1 at MAP_W-1, y-1 at y=0, or y+1 at MAP_H-1.
  - Out of bounds: bump=1 at N+1; go COOL, or IDLE if COOLDOWN=0. No map query is made.
  - In bounds: map_x/map_y <= tx/ty; go QUERY.
- QUERY (cycle N+1): sample map_tile, then:
  - road0 or road1: pos <= target; step_count += 1; bump=0.
  - stairs: same as road, and on_stairs=1.
  - wall or 1xx: position unchanged; map_x/map_y <= pos; bump=1.
  - Updated pos, step_count and the pulses are visible at N+2.
  - Next state is COOL, or IDLE if COOLDOWN=0.
- COOL: count COOLDOWN cycles, then go IDLE.
  - With COOLDOWN=4, the next request can be accepted at N+6 for a queried move, N+5 for an out-of-bounds one.
- map_x/map_y equal pos_x/pos_y whenever state is IDLE.
- bump and on_stairs are registered, never high together, and each lasts exactly 1 cycle.
- step_count saturates at all-ones and does not wrap.
- Requests while not IDLE are ignored, not queued. The requester must hold dir_valid or re-issue.
- respawn has highest priority in any state:
  - next cycle: pos = map_x/map_y = START; state IDLE; cooldown counter cleared.
  - Any in-flight QUERY is discarded: no pos change, no bump/on_stairs.
  - step_count is unchanged.
- respawn and dir_valid in the same cycle: respawn wins and the request is dropped (dir_ready=0 that cycle).
- Asynchronous rst mid-QUERY or mid-COOL returns all outputs immediately to their reset values.

Decomposition:
- Package game_pkg holds:
  - tile code constants (MAP_ROAD0/ROAD1/WALL/STAIRS);
  - direction encodings (DIR_UP/DOWN/LEFT/RIGHT);
  - MAP_W/MAP_H defaults;
  - FSM state encodings.
- One natural sub-module: move_cooldown_timer. It is a loadable down-counter with a done flag, handles COOLDOWN=0 and accepts a clear input driven by respawn.

Test Plan:
- Bench drives a behavioural map model with (2,1)=001 and (1,0)=010.
  - Right at (1,1): pos=(2,1) at N+2, step_count=1, no pulses.
  - Up at (1,1): bump for 1 cycle at N+2, pos stays (1,1), map_x/map_y back to (1,1).
- Model (14,1)=011, pos=(14,2), up -> pos=(14,1), on_stairs 1 cycle, step_count+1.
- Edge case: START_X=0, left -> bump at N+1, map_x/map_y never change, step_count unchanged.
- Cooldown case: dir_valid held high continuously with road everywhere, COOLDOWN=4.
  - Moves are accepted every 6 cycles; dir_ready low for 5 of every 6.
  - A request issued during COOL is ignored.
- Respawn case: pulse respawn in the QUERY cycle of a stairs move.
  - Next cycle pos=(START_X,START_Y), no on_stairs, step_count unchanged.
  - A respawn+dir_valid same-cycle request is dropped.
- Async rst asserted mid-COOL: pos, map_x/map_y and step_count return to reset values immediately; dir_ready=1 after release.
